// File: rtl/nf_fu_pkg.sv
// Shared types for the nf_i_fu instruction fetch unit.
// Optional feature macro: NF_FU_BYPASS_EN (see nf_i_fu.sv).
package nf_fu_pkg;

  // FETCH: normal sequential fetching.
  // DISCARD: a redirect happened while a request was outstanding. The old
  // request is held until its ack arrives, and that word is then dropped.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fu_state_t;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fu_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Redirect target: the halfword-scaled offset is added to the branch PC.
  // Any carry out of bit 31 is discarded.
  function automatic logic [31:0] br_target(input logic [31:0] pc,
                                            input logic [31:0] offset);
    return pc + {offset[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/nf_fu_fifo.sv
// Small circular buffer of fu_entry_t for the fetch unit.
// DEPTH must be a power of two and at least 2 so that the pointers wrap
// naturally. The read port returns zero when the buffer is empty.
// Flush takes priority over push and pop.
module nf_fu_fifo
  import nf_fu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fu_entry_t                wr_data,
  output fu_entry_t                rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  fu_entry_t        mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

  // A push into a full buffer is only accepted when a pop frees a slot
  // in the same cycle. A pop from an empty buffer is ignored.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Head of the buffer, forced to zero when nothing is stored.
  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data = mem_q[rd_ptr_q];
    end
  end

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It has no reset because the read port masks empty slots.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/nf_i_fu.sv
// Instruction fetch unit. It owns the PC, issues one word fetch at a time
// over req_i/ack_i, buffers the results, and presents them to decode.
// Optional feature macro: NF_FU_BYPASS_EN. When it is defined, a word that
// arrives while the buffer is empty is forwarded to decode in the same
// cycle as its ack.
//
// Handshakes:
//   Memory side: req_i and addr_i are held stable from the cycle they assert
//   until the cycle ack_i is high. At most one request is outstanding, and
//   ack_i is ignored while req_i is low. rd_i is valid in the ack_i cycle.
//   Decode side: instr, instr_pc and instr_vld are held while instr_vld=1
//   and instr_rdy=0. The head entry is consumed in any cycle where
//   instr_vld and instr_rdy are both high.
//
// dbg_state and dbg_count expose the FSM state and the buffer occupancy.
module nf_i_fu
  import nf_fu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  addr_i,
  output logic                         req_i,
  input  logic                         ack_i,
  input  logic [31:0]                  rd_i,
  output logic [31:0]                  instr,
  output logic [31:0]                  instr_pc,
  output logic                         instr_vld,
  input  logic                         instr_rdy,
  input  logic                         br_en,
  input  logic [31:0]                  br_pc,
  input  logic [31:0]                  br_offset,
  output fu_state_t                    dbg_state,
  output logic [$clog2(BUF_DEPTH):0]   dbg_count
);

  fu_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address of the request being discarded. It keeps addr_i stable after
  // pc has already moved to the redirect target.
  logic [31:0] hold_addr_q, hold_addr_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  fu_entry_t   fifo_wr;
  fu_entry_t   fifo_rd;
  logic [$clog2(BUF_DEPTH):0] fifo_count;

  logic        fire;
  logic [31:0] target;
  logic        byp_hit;
  logic        byp_vld;
  logic        byp_take;

  assign target = br_target(br_pc, br_offset);
  assign fire   = req_i && ack_i;

  // Memory request. Reset drops the request immediately, which abandons
  // any outstanding fetch.
  always_comb begin
    addr_i = pc_q;
    req_i  = 1'b0;
    if (state_q == DISCARD) begin
      addr_i = hold_addr_q;
      req_i  = !rst;
    end else begin
      req_i  = !rst && !fifo_full;
    end
  end

`ifdef NF_FU_BYPASS_EN
  // Forward the returning word directly when there is nothing older ahead
  // of it. A redirect in the same cycle cancels the forwarded word.
  assign byp_hit  = fifo_empty && (state_q == FETCH) && fire;
  assign byp_vld  = byp_hit && !br_en;
  assign byp_take = byp_vld && instr_rdy;
`else
  assign byp_hit  = 1'b0;
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // Decode-facing outputs. These show the buffer head, or the forwarded word.
  always_comb begin
    instr     = fifo_rd.instr;
    instr_pc  = fifo_rd.pc;
    instr_vld = !fifo_empty;
    if (byp_hit) begin
      instr     = rd_i;
      instr_pc  = addr_i;
      instr_vld = byp_vld;
    end
  end

  // Buffer control. A redirect flushes the buffer and wins over a pop
  // or a push in the same cycle.
  always_comb begin
    fifo_wr.pc    = pc_q;
    fifo_wr.instr = rd_i;
    fifo_push     = (state_q == FETCH) && fire && !br_en && !byp_take;
    fifo_pop      = !fifo_empty && instr_rdy;
  end

  // Next-state logic for the PC, the held address and the FSM state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    case (state_q)
      FETCH: begin
        if (br_en) begin
          pc_d = target;
          if (req_i && !ack_i) begin
            // The in-flight request must still complete; its data is dropped.
            state_d     = DISCARD;
            hold_addr_d = pc_q;
          end
        end else if (fire) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      DISCARD: begin
        if (br_en) begin
          pc_d = target;
        end
        if (ack_i) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers. Reset has priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  nf_fu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (br_en),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign dbg_state = state_q;
  assign dbg_count = fifo_count;

endmodule

// File: tb/tb_nf_i_fu.sv
// Directed testbench for nf_i_fu with the default parameters.
// Optional feature macro: NF_FU_BYPASS_EN. When it is defined, the bench
// adds a bypass scenario and adjusts the streaming expectations.
module tb_nf_i_fu;
  import nf_fu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic        req_i;
  logic        ack_i;
  logic [31:0] rd_i;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_vld;
  logic        instr_rdy;
  logic        br_en;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  fu_state_t   dbg_state;
  logic [1:0]  dbg_count;

  int checks = 0;
  int errors = 0;

`ifdef NF_FU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Clock and reset.
  always #5 clk = ~clk;

  nf_i_fu #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .rd_i      (rd_i),
    .instr     (instr),
    .instr_pc  (instr_pc),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
    .br_en     (br_en),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // Memory contents: a fixed pattern derived from the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Driver: set the memory response and the decode ready signal, then let
  // the combinational logic settle. The bench calls this just after a
  // falling edge.
  task automatic drive(input logic ack, input logic rdy);
    ack_i     = ack;
    instr_rdy = rdy;
    rd_i      = mem_word(addr_i);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    br_en     = 1'b0;
    br_pc     = '0;
    br_offset = '0;
    ack_i     = 1'b0;
    instr_rdy = 1'b0;
    rd_i      = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (req_i !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", req_i); end
    checks++; if (addr_i !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", addr_i); end
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0h expected 0", instr_vld); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, FETCH); end
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dbg_count); end
    rst = 1'b0;
    #1;
    checks++; if (req_i !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %0h expected 1", req_i); end
    @(negedge clk);
  endtask

  // Zero-wait-state memory with decode always ready: one word per cycle.
  task automatic test_stream();
    logic [31:0] exp_pc;
    logic        exp_vld;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1);
      exp_vld = BYP ? 1'b1 : (k >= 1);
      exp_pc  = BYP ? 32'(4 * k) : 32'(4 * (k - 1));
      checks++; if (addr_i !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, addr_i, 32'(4 * k)); end
      checks++; if (instr_vld !== exp_vld) begin errors++; $display("FAIL stream_vld[%0d]: got %0h expected %0h", k, instr_vld, exp_vld); end
      if (exp_vld) begin
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, instr_pc, exp_pc); end
        checks++; if (instr !== mem_word(exp_pc)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, instr, mem_word(exp_pc)); end
      end else begin
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL stream_empty_instr[%0d]: got %h expected 00000000", k, instr); end
      end
      @(negedge clk);
    end
  endtask

  // Decode stalls: the buffer fills to two entries, requests stop, and
  // the entries drain in order once decode is ready again.
  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0);
      if (k >= 1) begin
        checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d]: got vld=%0h pc=%h expected vld=1 pc=00000000", k, instr_vld, instr_pc); end
      end
      if (k >= 2) begin
        checks++; if (req_i !== 1'b0 || dbg_count !== 2'd2) begin errors++; $display("FAIL stall_full[%0d]: got req=%0h count=%0d expected req=0 count=2", k, req_i, dbg_count); end
      end
      @(negedge clk);
    end
    checks++; if (addr_i !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h expected 00000008", addr_i); end
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b1);
      checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'(4 * j)) begin errors++; $display("FAIL drain_pc[%0d]: got vld=%0h pc=%h expected vld=1 pc=%h", j, instr_vld, instr_pc, 32'(4 * j)); end
      checks++; if (instr !== mem_word(32'(4 * j))) begin errors++; $display("FAIL drain_instr[%0d]: got %h expected %h", j, instr, mem_word(32'(4 * j))); end
      @(negedge clk);
    end
  endtask

  // Redirect while the buffer holds two words: target 0x10 + (-8)*2 = 0x0.
  task automatic test_branch_flush();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
    end
    drive(1'b1, 1'b0);
    checks++; if (dbg_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", dbg_count); end
    br_en     = 1'b1;
    br_pc     = 32'h0000_0010;
    br_offset = 32'hFFFF_FFF8;
    @(negedge clk);
    br_en = 1'b0;
    drive(1'b0, 1'b0);
    checks++; if (dbg_count !== 2'd0 || instr_vld !== 1'b0) begin errors++; $display("FAIL flush_empty: got count=%0d vld=%0h expected count=0 vld=0", dbg_count, instr_vld); end
    checks++; if (addr_i !== 32'h0 || req_i !== 1'b1) begin errors++; $display("FAIL flush_addr: got addr=%h req=%0h expected addr=00000000 req=1", addr_i, req_i); end
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL flush_state: got %0d expected %0d", dbg_state, FETCH); end
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1);
    checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE_0000) begin errors++; $display("FAIL flush_next: got vld=%0h pc=%h instr=%h expected vld=1 pc=00000000 instr=c0de0000", instr_vld, instr_pc, instr); end
    @(negedge clk);
  endtask

  // Redirect while a request is outstanding: its late data must be dropped.
  task automatic test_branch_discard();
    do_reset();
    drive(1'b0, 1'b1);
    checks++; if (req_i !== 1'b1 || addr_i !== 32'h0) begin errors++; $display("FAIL disc_pre: got req=%0h addr=%h expected req=1 addr=00000000", req_i, addr_i); end
    br_en     = 1'b1;
    br_pc     = 32'h0000_0020;
    br_offset = 32'h0000_0010;
    @(negedge clk);
    br_en = 1'b0;
    for (int w = 0; w < 2; w++) begin
      drive(1'b0, 1'b1);
      checks++; if (dbg_state !== DISCARD || req_i !== 1'b1 || addr_i !== 32'h0 || instr_vld !== 1'b0) begin errors++; $display("FAIL disc_wait[%0d]: got st=%0d req=%0h addr=%h vld=%0h expected st=1 req=1 addr=00000000 vld=0", w, dbg_state, req_i, addr_i, instr_vld); end
      @(negedge clk);
    end
    ack_i     = 1'b1;
    rd_i      = 32'hDEAD_BEEF;
    instr_rdy = 1'b1;
    #1;
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL disc_ack_vld: got %0h expected 0", instr_vld); end
    @(negedge clk);
    drive(1'b0, 1'b1);
    checks++; if (dbg_state !== FETCH || addr_i !== 32'h40 || req_i !== 1'b1) begin errors++; $display("FAIL disc_resume: got st=%0d addr=%h req=%0h expected st=0 addr=00000040 req=1", dbg_state, addr_i, req_i); end
    checks++; if (instr_vld !== 1'b0 || dbg_count !== 2'd0) begin errors++; $display("FAIL disc_dropped: got vld=%0h count=%0d expected vld=0 count=0", instr_vld, dbg_count); end
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1);
    checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'hC0DE_0040) begin errors++; $display("FAIL disc_next: got vld=%0h pc=%h instr=%h expected vld=1 pc=00000040 instr=c0de0040", instr_vld, instr_pc, instr); end
    @(negedge clk);
  endtask

  // A second redirect while discarding retargets pc and the unit stays in
  // DISCARD. Final target: 0x100 + 0x8*2 = 0x110.
  task automatic test_rebranch();
    do_reset();
    drive(1'b0, 1'b1);
    br_en     = 1'b1;
    br_pc     = 32'h0000_0020;
    br_offset = 32'h0000_0010;
    @(negedge clk);
    drive(1'b0, 1'b1);
    br_pc     = 32'h0000_0100;
    br_offset = 32'h0000_0008;
    #1;
    @(negedge clk);
    br_en = 1'b0;
    drive(1'b1, 1'b1);
    checks++; if (dbg_state !== DISCARD || addr_i !== 32'h0) begin errors++; $display("FAIL rebr_state: got st=%0d addr=%h expected st=1 addr=00000000", dbg_state, addr_i); end
    @(negedge clk);
    drive(1'b1, 1'b1);
    checks++; if (dbg_state !== FETCH || addr_i !== 32'h110 || instr_vld !== 1'b0) begin errors++; $display("FAIL rebr_resume: got st=%0d addr=%h vld=%0h expected st=0 addr=00000110 vld=0", dbg_state, addr_i, instr_vld); end
    @(negedge clk);
    drive(1'b1, 1'b1);
    checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'h110) begin errors++; $display("FAIL rebr_next: got vld=%0h pc=%h expected vld=1 pc=00000110", instr_vld, instr_pc); end
    @(negedge clk);
  endtask

  // Redirect in the same cycle as an ack: the data is dropped and no
  // discard is needed. Target: 0x80 + 0x20*2 = 0xC0.
  task automatic test_branch_ack();
    do_reset();
    drive(1'b1, 1'b1);
    br_en     = 1'b1;
    br_pc     = 32'h0000_0080;
    br_offset = 32'h0000_0020;
    @(negedge clk);
    br_en = 1'b0;
    drive(1'b1, 1'b1);
    checks++; if (dbg_state !== FETCH || addr_i !== 32'hC0 || instr_vld !== 1'b0 || dbg_count !== 2'd0) begin errors++; $display("FAIL brack_state: got st=%0d addr=%h vld=%0h count=%0d expected st=0 addr=000000c0 vld=0 count=0", dbg_state, addr_i, instr_vld, dbg_count); end
    @(negedge clk);
    drive(1'b1, 1'b1);
    checks++; if (instr_vld !== 1'b1 || instr_pc !== 32'hC0) begin errors++; $display("FAIL brack_next: got vld=%0h pc=%h expected vld=1 pc=000000c0", instr_vld, instr_pc); end
    @(negedge clk);
  endtask

  // Reset while a request is outstanding and one word is buffered.
  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0);
    checks++; if (dbg_count !== 2'd1 || req_i !== 1'b1 || addr_i !== 32'h4) begin errors++; $display("FAIL rmid_pre: got count=%0d req=%0h addr=%h expected count=1 req=1 addr=00000004", dbg_count, req_i, addr_i); end
    rst = 1'b1;
    #1;
    checks++; if (req_i !== 1'b0) begin errors++; $display("FAIL rmid_req_drop: got %0h expected 0", req_i); end
    @(negedge clk);
    #1;
    checks++; if (instr_vld !== 1'b0 || addr_i !== 32'h0 || dbg_state !== FETCH || dbg_count !== 2'd0) begin errors++; $display("FAIL rmid_after: got vld=%0h addr=%h st=%0d count=%0d expected vld=0 addr=00000000 st=0 count=0", instr_vld, addr_i, dbg_state, dbg_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef NF_FU_BYPASS_EN
  // Same-cycle forwarding of a word that arrives at an empty buffer.
  task automatic test_bypass();
    do_reset();
    ack_i     = 1'b1;
    instr_rdy = 1'b1;
    rd_i      = 32'h0000_0013;
    #1;
    checks++; if (instr !== 32'h13 || instr_vld !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL byp_same: got instr=%h vld=%0h pc=%h expected instr=00000013 vld=1 pc=00000000", instr, instr_vld, instr_pc); end
    @(negedge clk);
    ack_i = 1'b0;
    #1;
    checks++; if (dbg_count !== 2'd0) begin errors++; $display("FAIL byp_count: got %0d expected 0", dbg_count); end
    @(negedge clk);
  endtask
`endif

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_branch_discard();
    test_rebranch();
    test_branch_ack();
    test_reset_mid();
`ifdef NF_FU_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf_i_fu.md
Name: nf_i_fu

Overview:
- Instruction fetch unit, directly upstream of the instruction decode stage.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words with their PC in a small FIFO and presents the FIFO head to decode with a valid/ready handshake.
- Accepts branch redirects from downstream and flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- addr_i  output  32  instruction memory word address.
- req_i  output  1  fetch request.
- ack_i  input  1  memory acknowledge; rd_i valid in the same cycle.
- rd_i  input  32  instruction memory read data.
- instr  output  32  instruction to decode (FIFO head).
- instr_pc  output  32  PC of instr.
- instr_vld  output  1  instr/instr_pc valid.
- instr_rdy  input  1  decode accepts head this cycle.
- br_en  input  1  one-cycle redirect strobe (pc_src from decode).
- br_pc  input  32  PC of the branch instruction.
- br_offset  input  32  sign-extended immediate from decode.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, FIFO empty, state=FETCH, req_i=0, addr_i=RESET_PC, instr_vld=0, instr=0, instr_pc=0.
- Memory protocol:
  - addr_i = pc register.
  - Once asserted, req_i and addr_i stay stable until the ack_i cycle.
  - At most one request outstanding.
  - ack_i without req_i is ignored.
- States:
  - FETCH: req_i = (count < BUF_DEPTH).
    - On ack_i: push {pc, rd_i}, then pc <= pc+4.
    - If count==BUF_DEPTH, req_i=0 and the unit waits.
  - DISCARD: req_i=1 with the old addr_i held; on ack_i, drop rd_i and go to FETCH.
- Redirect target: target = br_pc + {br_offset[30:0],1'b0}, mod 2^32, wrap ignored.
- On br_en:
  - FIFO flushed (count=0, pointers reset), pc <= target.
  - If req_i=1 and ack_i=0 this cycle: go to DISCARD.
  - If ack_i=1 this cycle: drop the data and stay in FETCH.
  - If no request is outstanding: stay in FETCH.
  - A pop in the same cycle is a don't-care, since the FIFO is flushed.
- br_en during DISCARD: update pc to the new target and remain in DISCARD.
- Pop and push:
  - Pop when instr_vld & instr_rdy.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers are log2(BUF_DEPTH) bits and wrap naturally.
- Output latency: a word is pushed on the ack edge, so instr_vld rises the cycle after ack_i.
- Throughput: one instruction per cycle with a zero-wait-state memory and instr_rdy=1.
- Stall: with instr_rdy=0, instr/instr_pc/instr_vld hold. Requests stop once count reaches BUF_DEPTH.
- Reset mid-request: rst wins over everything. The outstanding request is abandoned; memory must tolerate req_i dropping.
- instr and instr_pc read 0 when the FIFO is empty.

Optional Feature:
- Macro: NF_FU_BYPASS_EN.
- Defined: when the FIFO is empty, state is FETCH and ack_i=1, rd_i/addr_i are forwarded combinationally to instr/instr_pc with instr_vld=1 in the same cycle.
  - If instr_rdy=1, the word is not pushed.
  - br_en in that cycle suppresses the bypass valid.
- Undefined: no combinational path from rd_i to instr; latency is as above.

Decomposition:
- Package nf_fu_pkg holds:
  - enum fu_state_t {FETCH, DISCARD};
  - struct fu_entry_t {pc[31:0], instr[31:0]};
  - localparam PC_STEP=4.
- Sub-module nf_fu_fifo holds:
  - parameter DEPTH;
  - push/pop/flush, data in/out as fu_entry_t, count, empty/full.

Test Plan:
- Reset release, ack_i=1 every cycle, instr_rdy=1 -> addr_i 0x0,0x4,0x8,...; instr_vld from 2nd cycle; instr_pc tracks 0x0,0x4 consecutively.
- instr_rdy=0 for 6 cycles -> exactly 2 words buffered (0x0,0x4); req_i low; after instr_rdy=1, 0x0 then 0x4 delivered, no loss or duplicate.
- br_en with br_pc=0x10, br_offset=0xFFFF_FFF8 (−8) while FIFO holds 2 words -> FIFO empty next cycle; next addr_i=0x0; next delivered instr_pc=0x0.
- br_en while req_i=1, ack_i=0 (target 0x40); ack_i arrives 3 cycles later with 0xDEAD_BEEF -> word dropped; next request addr 0x40; instr_vld never shows 0xDEAD_BEEF.
- rst asserted mid-request with 1 word buffered -> next cycle instr_vld=0, addr_i=RESET_PC, state FETCH.
- NF_FU_BYPASS_EN, empty FIFO, ack_i=1 with rd_i=0x0000_0013 -> instr=0x13, instr_vld=1 same cycle; with instr_rdy=1 the FIFO count stays 0.
